// File: rtl/ysyx_exu_rs.sv
// Reservation station: holds dispatched ALU ops until both source tags resolve,
// issues the lowest-index ready entry and registers the FU result onto the CDB.
module ysyx_exu_rs #(
  parameter  int unsigned RS_SIZE  = 4,
  parameter  int unsigned ROB_SIZE = 8,
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned TW       = $clog2(ROB_SIZE) + 1,
  localparam int unsigned IW       = $clog2(RS_SIZE)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  // dispatch
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [4:0]      disp_alu_op,
  input  logic [XLEN-1:0] disp_op1,
  input  logic [XLEN-1:0] disp_op2,
  input  logic [31:0]     disp_imm,
  input  logic [XLEN-1:0] disp_pc,
  input  logic [TW-1:0]   disp_qj,
  input  logic [TW-1:0]   disp_qk,
  input  logic [TW-1:0]   disp_dest,
  output logic [IW-1:0]   disp_rs_idx,
  // issue
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [4:0]      iss_alu_op,
  output logic [XLEN-1:0] iss_op1,
  output logic [XLEN-1:0] iss_op2,
  output logic [31:0]     iss_imm,
  output logic [XLEN-1:0] iss_pc,
  output logic [TW-1:0]   iss_dest,
  // FU return
  input  logic            fu_valid,
  input  logic [TW-1:0]   fu_dest,
  input  logic [XLEN-1:0] fu_result,
  // writeback / CDB
  output logic            wb_valid,
  output logic [TW-1:0]   wb_dest,
  output logic [XLEN-1:0] wb_result
);

  logic [RS_SIZE-1:0] r_valid;
  logic [4:0]         r_alu_op [RS_SIZE];
  logic [XLEN-1:0]    r_op1    [RS_SIZE];
  logic [XLEN-1:0]    r_op2    [RS_SIZE];
  logic [31:0]        r_imm    [RS_SIZE];
  logic [XLEN-1:0]    r_pc     [RS_SIZE];
  logic [TW-1:0]      r_qj     [RS_SIZE];
  logic [TW-1:0]      r_qk     [RS_SIZE];
  logic [TW-1:0]      r_dest   [RS_SIZE];

  logic               r_wb_valid;
  logic [TW-1:0]      r_wb_dest;
  logic [XLEN-1:0]    r_wb_result;

  logic [RS_SIZE-1:0] w_ready;
  logic               w_any_free;
  logic [IW-1:0]      w_free_idx;
  logic               w_any_ready;
  logic [IW-1:0]      w_iss_idx;
  logic               w_do_disp;
  logic               w_do_iss;
  logic               w_byp_j;
  logic               w_byp_k;

  // Lowest free slot and lowest ready slot, both from registered state only
  always_comb begin
    w_any_free  = 1'b0;
    w_free_idx  = '0;
    w_any_ready = 1'b0;
    w_iss_idx   = '0;
    w_ready     = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_valid[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
      if (!r_valid[i] && !w_any_free) begin
        w_any_free = 1'b1;
        w_free_idx = IW'(i);
      end
      if (w_ready[i] && !w_any_ready) begin
        w_any_ready = 1'b1;
        w_iss_idx   = IW'(i);
      end
    end
  end

  assign w_do_disp = disp_valid && w_any_free;
  assign w_do_iss  = w_any_ready && iss_ready;
  assign w_byp_j   = r_wb_valid && (disp_qj != '0) && (disp_qj == r_wb_dest);
  assign w_byp_k   = r_wb_valid && (disp_qk != '0) && (disp_qk == r_wb_dest);

  assign disp_ready  = w_any_free;
  assign disp_rs_idx = w_free_idx;
  assign iss_valid   = w_any_ready;
  assign iss_alu_op  = r_alu_op[w_iss_idx];
  assign iss_op1     = r_op1[w_iss_idx];
  assign iss_op2     = r_op2[w_iss_idx];
  assign iss_imm     = r_imm[w_iss_idx];
  assign iss_pc      = r_pc[w_iss_idx];
  assign iss_dest    = r_dest[w_iss_idx];
  assign wb_valid    = r_wb_valid;
  assign wb_dest     = r_wb_dest;
  assign wb_result   = r_wb_result;

  // Valid bits and CDB valid; flush drops everything including the in-flight FU result
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_valid    <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      r_wb_valid <= fu_valid;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (w_do_iss && (w_iss_idx == IW'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (w_do_disp && (w_free_idx == IW'(i))) begin
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Payloads carry no reset; every consumer is qualified by a valid bit
  always_ff @(posedge clock) begin
    if (fu_valid && !flush) begin
      r_wb_dest   <= fu_dest;
      r_wb_result <= fu_result;
    end
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (w_do_disp && (w_free_idx == IW'(i))) begin
        r_alu_op[i] <= disp_alu_op;
        r_imm[i]    <= disp_imm;
        r_pc[i]     <= disp_pc;
        r_dest[i]   <= disp_dest;
        r_op1[i]    <= w_byp_j ? r_wb_result : disp_op1;
        r_qj[i]     <= w_byp_j ? '0 : disp_qj;
        r_op2[i]    <= w_byp_k ? r_wb_result : disp_op2;
        r_qk[i]     <= w_byp_k ? '0 : disp_qk;
      end else if (r_valid[i] && r_wb_valid) begin
        if ((r_qj[i] != '0) && (r_qj[i] == r_wb_dest)) begin
          r_op1[i] <= r_wb_result;
          r_qj[i]  <= '0;
        end
        if ((r_qk[i] != '0) && (r_qk[i] == r_wb_dest)) begin
          r_op2[i] <= r_wb_result;
          r_qk[i]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_exu_rs.sv
// Directed bench for ysyx_exu_rs: dispatch/issue, wakeup, bypass, full, priority, flush, reset.
module tb_ysyx_exu_rs;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 4;
  localparam int unsigned IW   = 2;

  logic            clock = 1'b0;
  logic            reset, flush;
  logic            disp_valid, disp_ready;
  logic [4:0]      disp_alu_op;
  logic [XLEN-1:0] disp_op1, disp_op2, disp_pc;
  logic [31:0]     disp_imm;
  logic [TW-1:0]   disp_qj, disp_qk, disp_dest;
  logic [IW-1:0]   disp_rs_idx;
  logic            iss_valid, iss_ready;
  logic [4:0]      iss_alu_op;
  logic [XLEN-1:0] iss_op1, iss_op2, iss_pc;
  logic [31:0]     iss_imm;
  logic [TW-1:0]   iss_dest;
  logic            fu_valid;
  logic [TW-1:0]   fu_dest;
  logic [XLEN-1:0] fu_result;
  logic            wb_valid;
  logic [TW-1:0]   wb_dest;
  logic [XLEN-1:0] wb_result;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_exu_rs dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_op(disp_alu_op),
    .disp_op1(disp_op1), .disp_op2(disp_op2), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_dest(disp_dest), .disp_rs_idx(disp_rs_idx),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_alu_op(iss_alu_op),
    .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_dest(iss_dest),
    .fu_valid(fu_valid), .fu_dest(fu_dest), .fu_result(fu_result),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic disp(input logic [TW-1:0] qj, input logic [TW-1:0] qk, input logic [TW-1:0] dest,
                      input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2);
    disp_valid  = 1'b1;
    disp_alu_op = 5'(dest);
    disp_qj     = qj;
    disp_qk     = qk;
    disp_dest   = dest;
    disp_op1    = op1;
    disp_op2    = op2;
    disp_imm    = 32'h1000 + 32'(dest);
    disp_pc     = 32'h8000_0000 + 32'(dest);
  endtask

  task automatic fu(input logic [TW-1:0] dest, input logic [XLEN-1:0] res);
    fu_valid  = 1'b1;
    fu_dest   = dest;
    fu_result = res;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; iss_ready = 1'b0;
    disp_valid = 1'b0; disp_alu_op = '0; disp_op1 = '0; disp_op2 = '0; disp_imm = '0;
    disp_pc = '0; disp_qj = '0; disp_qk = '0; disp_dest = '0;
    fu_valid = 1'b0; fu_dest = '0; fu_result = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    check("rst_disp_idx",   64'(disp_rs_idx), 64'd0);
    check("rst_iss_valid",  64'(iss_valid), 64'd0);
    check("rst_wb_valid",   64'(wb_valid), 64'd0);

    // ready-at-dispatch op issues the next cycle, slot freed after issue
    iss_ready = 1'b1;
    disp(4'd0, 4'd0, 4'd3, 32'd5, 32'd6);
    check("a_idx", 64'(disp_rs_idx), 64'd0);
    tick();
    disp_valid = 1'b0;
    check("a_iss_valid", 64'(iss_valid), 64'd1);
    check("a_iss_dest",  64'(iss_dest), 64'd3);
    check("a_iss_op1",   64'(iss_op1), 64'd5);
    check("a_iss_op2",   64'(iss_op2), 64'd6);
    check("a_iss_imm",   64'(iss_imm), 64'h1003);
    check("a_iss_pc",    64'(iss_pc), 64'h8000_0003);
    tick();
    check("a_freed_iss", 64'(iss_valid), 64'd0);
    check("a_freed_idx", 64'(disp_rs_idx), 64'd0);

    // qj pending, woken through FU return and CDB
    disp(4'd2, 4'd0, 4'd5, 32'd0, 32'd9);
    tick();
    disp_valid = 1'b0;
    check("b_wait0", 64'(iss_valid), 64'd0);
    tick();
    check("b_wait1", 64'(iss_valid), 64'd0);
    fu(4'd2, 32'hAA);
    tick();
    fu_valid = 1'b0;
    check("b_wb_valid",  64'(wb_valid), 64'd1);
    check("b_wb_dest",   64'(wb_dest), 64'd2);
    check("b_wb_result", 64'(wb_result), 64'hAA);
    check("b_not_yet",   64'(iss_valid), 64'd0);
    tick();
    check("b_iss_valid", 64'(iss_valid), 64'd1);
    check("b_iss_op1",   64'(iss_op1), 64'hAA);
    check("b_iss_op2",   64'(iss_op2), 64'd9);
    check("b_iss_dest",  64'(iss_dest), 64'd5);
    check("b_wb_drop",   64'(wb_valid), 64'd0);
    check("b_wb_hold",   64'(wb_dest), 64'd2);
    check("b_wb_hold_r", 64'(wb_result), 64'hAA);
    tick();
    check("b_freed", 64'(iss_valid), 64'd0);

    // dispatch-time bypass from the CDB
    fu(4'd4, 32'd7);
    tick();
    fu_valid = 1'b0;
    disp(4'd0, 4'd4, 4'd6, 32'd1, 32'h99);
    check("c_wb_valid", 64'(wb_valid), 64'd1);
    check("c_pre_iss",  64'(iss_valid), 64'd0);
    tick();
    disp_valid = 1'b0;
    check("c_iss_valid", 64'(iss_valid), 64'd1);
    check("c_iss_op2",   64'(iss_op2), 64'd7);
    check("c_iss_dest",  64'(iss_dest), 64'd6);
    tick();
    check("c_freed", 64'(iss_valid), 64'd0);

    // fill all four with distinct pending tags (entry k waits on tag k+1, dest k+1)
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(4'(k + 1), 4'd0, 4'(k + 1), 32'd0, 32'(k));
      check("d_fill_ready", 64'(disp_ready), 64'd1);
      check("d_fill_idx",   64'(disp_rs_idx), 64'(k));
      tick();
    end
    disp_valid = 1'b0;
    check("d_full", 64'(disp_ready), 64'd0);
    disp(4'd0, 4'd0, 4'd7, 32'd0, 32'd0);
    tick();
    disp_valid = 1'b0;
    check("d_fifth_dropped", 64'(iss_valid), 64'd0);
    check("d_still_full",    64'(disp_ready), 64'd0);

    // unmatched tag wakes nothing
    fu(4'd6, 32'h66);
    tick();
    fu_valid = 1'b0;
    tick();
    check("d_nomatch", 64'(iss_valid), 64'd0);

    // wake entry 2 only and issue it
    fu(4'd3, 32'h33);
    tick();
    fu_valid = 1'b0;
    tick();
    check("d_w_iss_valid", 64'(iss_valid), 64'd1);
    check("d_w_iss_dest",  64'(iss_dest), 64'd3);
    check("d_w_iss_op1",   64'(iss_op1), 64'h33);
    check("d_w_full",      64'(disp_ready), 64'd0);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("d_freed_ready", 64'(disp_ready), 64'd1);
    check("d_freed_idx",   64'(disp_rs_idx), 64'd2);
    check("d_freed_iss",   64'(iss_valid), 64'd0);

    // entries 1 and 3 ready: lower index issues first
    fu(4'd2, 32'h22);
    tick();
    fu(4'd4, 32'h44);
    tick();
    fu_valid = 1'b0;
    tick();
    check("e_iss_valid", 64'(iss_valid), 64'd1);
    check("e_first",     64'(iss_dest), 64'd2);
    check("e_first_op1", 64'(iss_op1), 64'h22);
    iss_ready = 1'b1;
    tick();
    check("e_second",     64'(iss_dest), 64'd4);
    check("e_second_op1", 64'(iss_op1), 64'h44);
    check("e_second_op2", 64'(iss_op2), 64'd3);
    tick();
    check("e_drained", 64'(iss_valid), 64'd0);
    check("e_idx",     64'(disp_rs_idx), 64'd1);

    // three entries valid, then flush with dispatch and FU return in the same cycle
    iss_ready = 1'b0;
    disp(4'd5, 4'd0, 4'd1, 32'd0, 32'd0);
    tick();
    disp(4'd5, 4'd0, 4'd2, 32'd0, 32'd0);
    tick();
    check("f_three_full_idx", 64'(disp_rs_idx), 64'd3);
    flush = 1'b1;
    disp(4'd0, 4'd0, 4'd7, 32'd0, 32'd0);
    fu(4'd5, 32'h55);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    fu_valid = 1'b0;
    check("f_iss_valid",  64'(iss_valid), 64'd0);
    check("f_disp_ready", 64'(disp_ready), 64'd1);
    check("f_disp_idx",   64'(disp_rs_idx), 64'd0);
    check("f_wb_valid",   64'(wb_valid), 64'd0);
    tick();
    check("f_after", 64'(iss_valid), 64'd0);

    // reset wins over a simultaneous dispatch
    disp(4'd0, 4'd0, 4'd1, 32'd1, 32'd1);
    fu(4'd1, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    disp_valid = 1'b0;
    fu_valid = 1'b0;
    check("g_iss_valid", 64'(iss_valid), 64'd0);
    check("g_wb_valid",  64'(wb_valid), 64'd0);
    check("g_idx",       64'(disp_rs_idx), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
